// File: rtl/dma_block_sequencer_pkg.sv
// Shared types for the SD host DMA block sequencer: transfer codes, FSM states, defaults.
// SDH_BLOCK_GAP_EN adds the block-gap (GAP) state.
package dma_block_sequencer_pkg;

  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned STOP_TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    XFER_SINGLE        = 2'b00,
    XFER_INFINITE      = 2'b01,
    XFER_MULTIPLE      = 2'b10,
    XFER_STOP_MULTIPLE = 2'b11
  } xfer_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_STOP = 3'd4,
    ST_FIN  = 3'd5
`ifdef SDH_BLOCK_GAP_EN
    , ST_GAP = 3'd6
`endif
  } seq_state_e;

  // Transfer types that end with CMD12 when aborted.
  function automatic logic abortable(input xfer_type_e t);
    return (t == XFER_MULTIPLE) || (t == XFER_INFINITE);
  endfunction

endpackage

// File: rtl/dma_block_sequencer_if.sv
// Handshake bundle between the sequencer and its decoder / data path / command issuer.
// SDH_BLOCK_GAP_EN adds Gap_Req, Continue and Gap_Stopped.
interface dma_block_sequencer_if #(
  parameter int unsigned CNT_W = dma_block_sequencer_pkg::CNT_W_DEF
);

  logic             Start;
  logic [1:0]       Transfer_Type;
  logic [CNT_W-1:0] Block_Count;
  logic             Abort;
  logic             Block_Req;
  logic             Block_Done;
  logic             Stop_Req;
  logic             Stop_Ack;
  logic             Busy;
  logic             Done;
  logic             Stop_Err;
  logic [CNT_W-1:0] Blocks_Left;
  logic [CNT_W-1:0] Blocks_Xfered;
`ifdef SDH_BLOCK_GAP_EN
  logic             Gap_Req;
  logic             Continue;
  logic             Gap_Stopped;
`endif

  modport master (
    output Start, Transfer_Type, Block_Count, Abort, Block_Done, Stop_Ack,
`ifdef SDH_BLOCK_GAP_EN
    output Gap_Req, Continue,
    input  Gap_Stopped,
`endif
    input  Block_Req, Stop_Req, Busy, Done, Stop_Err, Blocks_Left, Blocks_Xfered
  );

  modport slave (
    input  Start, Transfer_Type, Block_Count, Abort, Block_Done, Stop_Ack,
`ifdef SDH_BLOCK_GAP_EN
    input  Gap_Req, Continue,
    output Gap_Stopped,
`endif
    output Block_Req, Stop_Req, Busy, Done, Stop_Err, Blocks_Left, Blocks_Xfered
  );

endinterface

// File: rtl/sdh_stop_timer.sv
// CMD12 acknowledge timeout: counts while enabled, clears when disabled,
// flags expiry on the cycle the count would reach LIMIT.
module sdh_stop_timer #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = en ? (cnt_q + CW'(1)) : '0;
    expired_c = en && (cnt_q == CW'(LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dma_block_sequencer.sv
// Block-level sequencer for the SD host DMA: one Block_Req per block, block accounting,
// and CMD12 request at the end of multi-block/aborted transfers. Option: SDH_BLOCK_GAP_EN.
module dma_block_sequencer
  import dma_block_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned STOP_TIMEOUT = STOP_TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dma_block_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  xfer_type_e       xfer_type_q, xfer_type_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] blocks_left_q, blocks_left_d;
  logic [CNT_W-1:0] blocks_xfered_q, blocks_xfered_d;
  logic             block_req_q, block_req_d;
  logic             stop_req_q, stop_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stop_err_q, stop_err_d;
`ifdef SDH_BLOCK_GAP_EN
  logic             gap_stopped_q, gap_stopped_d;
`endif
  logic             timer_expired_c;

  sdh_stop_timer #(.LIMIT(STOP_TIMEOUT)) u_stop_timer (
    .clk       (CLK),
    .rst       (RESET),
    .en        (state_q == ST_STOP),
    .expired_c (timer_expired_c)
  );

  // Next-state and registered-output logic; outputs follow the next state.
  always_comb begin
    state_d         = state_q;
    xfer_type_d     = xfer_type_q;
    count_d         = count_q;
    blocks_left_d   = blocks_left_q;
    blocks_xfered_d = blocks_xfered_q;
    stop_err_d      = stop_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          state_d         = ST_LOAD;
          xfer_type_d     = xfer_type_e'(bus.Transfer_Type);
          count_d         = bus.Block_Count;
          stop_err_d      = 1'b0;
          blocks_xfered_d = '0;
        end
      end

      ST_LOAD: begin
        case (xfer_type_q)
          XFER_SINGLE: begin
            blocks_left_d = CNT_W'(1);
            state_d       = ST_REQ;
          end
          XFER_INFINITE: begin
            blocks_left_d = '0;
            state_d       = ST_REQ;
          end
          XFER_MULTIPLE: begin
            blocks_left_d = count_q;
            state_d       = (count_q == '0) ? ST_STOP : ST_REQ;
          end
          default: begin
            blocks_left_d = '0;
            state_d       = ST_STOP;
          end
        endcase
      end

      ST_REQ: state_d = ST_WAIT;

      ST_WAIT: begin
        if (bus.Block_Done) begin
          blocks_xfered_d = blocks_xfered_q + CNT_W'(1);
          if ((xfer_type_q != XFER_INFINITE) && (blocks_left_q != '0))
            blocks_left_d = blocks_left_q - CNT_W'(1);
          if (xfer_type_q == XFER_SINGLE)
            state_d = ST_FIN;
          else if ((xfer_type_q == XFER_MULTIPLE) && (blocks_left_d == '0))
            state_d = ST_STOP;
          else if (abortable(xfer_type_q) && bus.Abort)
            state_d = ST_STOP;
`ifdef SDH_BLOCK_GAP_EN
          else if (bus.Gap_Req)
            state_d = ST_GAP;
`endif
          else
            state_d = ST_REQ;
        end
      end

`ifdef SDH_BLOCK_GAP_EN
      ST_GAP: begin
        if (bus.Abort)         state_d = ST_STOP;
        else if (bus.Continue) state_d = ST_REQ;
      end
`endif

      // An ack arriving on the expiry cycle still counts as success.
      ST_STOP: begin
        if (bus.Stop_Ack) begin
          state_d = ST_FIN;
        end else if (timer_expired_c) begin
          stop_err_d = 1'b1;
          state_d    = ST_FIN;
        end
      end

      ST_FIN:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    block_req_d = (state_d == ST_REQ);
    stop_req_d  = (state_d == ST_STOP);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
`ifdef SDH_BLOCK_GAP_EN
    gap_stopped_d = (state_d == ST_GAP);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= ST_IDLE;
      xfer_type_q     <= XFER_SINGLE;
      count_q         <= '0;
      blocks_left_q   <= '0;
      blocks_xfered_q <= '0;
      block_req_q     <= 1'b0;
      stop_req_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      stop_err_q      <= 1'b0;
`ifdef SDH_BLOCK_GAP_EN
      gap_stopped_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      xfer_type_q     <= xfer_type_d;
      count_q         <= count_d;
      blocks_left_q   <= blocks_left_d;
      blocks_xfered_q <= blocks_xfered_d;
      block_req_q     <= block_req_d;
      stop_req_q      <= stop_req_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      stop_err_q      <= stop_err_d;
`ifdef SDH_BLOCK_GAP_EN
      gap_stopped_q   <= gap_stopped_d;
`endif
    end
  end

  assign bus.Block_Req     = block_req_q;
  assign bus.Stop_Req      = stop_req_q;
  assign bus.Busy          = busy_q;
  assign bus.Done          = done_q;
  assign bus.Stop_Err      = stop_err_q;
  assign bus.Blocks_Left   = blocks_left_q;
  assign bus.Blocks_Xfered = blocks_xfered_q;
`ifdef SDH_BLOCK_GAP_EN
  assign bus.Gap_Stopped   = gap_stopped_q;
`endif

endmodule
